sram_read_ctrl: RTL
===================

# sram_read_ctrl

Synchronous read sequencer for the 16x8 single-bit SRAM array; the read-side counterpart of the write path. It accepts an active-low read request with one-hot row/column selects and sequences precharge, wordline/sense enable, and data capture. It returns the sensed cell bit with a one-cycle valid pulse. It sits between the array's bitline/sense-amp outputs and the memory top-level controller.

## Interface
Parameters:
- Rows, 16, number of array rows (width of row_sel / wl_row)
- Cols, 8, number of array columns (width of col_sel / bl_col)
- SENSE_CYCLES, 2, cycles wordline+sense enable are held; legal range 1..15

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- re_n  input  1  active-low read request
- row_sel  input  Rows  one-hot row select
- col_sel  input  Cols  one-hot column select
- bl_in  input  1  sensed bit from the selected column's sense amp
- precharge  output  1  bitline precharge enable
- wl_row  output  Rows  registered wordline drive (copy of captured row_sel)
- bl_col  output  Cols  registered column mux select (copy of captured col_sel)
- sense_en  output  1  sense-amp enable
- dout  output  1  last read data bit, held until next completed read
- rd_valid  output  1  one-cycle pulse: dout updated
- busy  output  1  high while a read is in flight (state != IDLE)
- sel_err  output  1  one-cycle pulse: request rejected (see Configuration)

## Operation
- States: IDLE, PRECH, SENSE. 4-bit sense counter.
- Accept condition (IDLE only): ~re_n & |row_sel & |col_sel. On accept: capture row_sel/col_sel into internal regs, go PRECH.
- Requests while busy are ignored (no queueing, no error). Request with zero row_sel or col_sel is ignored.
- PRECH: precharge=1 for exactly 1 cycle; wl_row/bl_col/sense_en = 0; next SENSE, counter <= SENSE_CYCLES-1.
- SENSE: wl_row=captured row, bl_col=captured col, sense_en=1, precharge=0; counter decrements each cycle; when counter==0: dout <= bl_in, rd_valid <= 1, go IDLE.
- IDLE: precharge, sense_en, wl_row, bl_col all 0; rd_valid 0 except the completion pulse.
- dout changes only on completion; retained across idle periods.
- Array control outputs (precharge, wl_row, bl_col, sense_en) are decoded from state/registers, never directly from inputs.

## Timing
- Reset values: state IDLE, precharge 0, wl_row 0, bl_col 0, sense_en 0, dout 0, rd_valid 0, busy 0, sel_err 0, counter 0.
- Accept at edge E: PRECH in cycle E..E+1; SENSE in cycles E+1..E+1+SENSE_CYCLES; bl_in sampled at edge E+1+SENSE_CYCLES; rd_valid high for cycle E+1+S..E+2+S.
- Latency request-sample to rd_valid: SENSE_CYCLES+1 edges (3 at default).
- Back-to-back: rd_valid cycle is IDLE with busy=0; a request present in that cycle is accepted at its closing edge. Throughput one read per SENSE_CYCLES+2 cycles.
- rst asserted mid-read: at that edge all outputs take reset values; aborted read never produces rd_valid; dout cleared to 0.
- rst and a request at the same edge: reset wins, request dropped.

## Configuration
- Macro ONEHOT_CHECK_EN.
- Defined: accept condition additionally checks row_sel and col_sel each have exactly one bit set. A request meeting the base accept condition but failing this check stays in IDLE, captures nothing, and pulses sel_err for one cycle (the cycle after the sampling edge). dout unchanged.
- Undefined: no check; multi-hot selects are captured and driven to wl_row/bl_col as-is; sel_err tied 0.

## Test plan
- Reset: hold rst 2 cycles with re_n=0, row_sel=16'h0001, col_sel=8'h01 -> all outputs 0, busy 0, no rd_valid.
- Single read, SENSE_CYCLES=2: row_sel=16'h0008, col_sel=8'h04, bl_in=1 -> precharge 1 cycle, wl_row=16'h0008/bl_col=8'h04/sense_en for 2 cycles, dout=1 with rd_valid pulse 3 edges after accept.
- Back-to-back: hold re_n=0 across two reads with bl_in 1 then 0 -> second accept in rd_valid cycle, rd_valid pulses 4 cycles apart, dout 1 then 0.
- Busy ignore: new request with row_sel=16'h8000 during SENSE -> wl_row stays at first row, exactly one rd_valid.
- Reset mid-SENSE: assert rst in SENSE -> next cycle all outputs 0, dout 0, no rd_valid afterwards.
- ONEHOT_CHECK_EN defined, row_sel=16'h0003, col_sel=8'h01 -> sel_err single pulse, busy stays 0, no rd_valid; undefined -> read proceeds with wl_row=16'h0003.

Source files
------------

// File: rtl/sram_read_ctrl.sv
// sram_read_ctrl: read sequencer for the 16x8 single-bit SRAM array.
// Sequences a bitline precharge, then wordline and sense enable, then captures
// the sensed bit and pulses rd_valid for one cycle.
//
// Handshake: a read is requested by holding re_n low with non-zero row_sel and
// col_sel while busy is low. The request is taken at that rising edge. Requests
// seen while busy is high are dropped and not queued. The result is reported by
// a one-cycle rd_valid pulse. dout keeps its value until the next read completes.
//
// Optional build macro ONEHOT_CHECK_EN: when defined, a request whose row or
// column select is not exactly one-hot is refused and pulses sel_err. When the
// macro is not defined, selects are used exactly as given and sel_err is held 0.
// SENSE_CYCLES must be in 1..15 because it is loaded into a 4-bit counter.
module sram_read_ctrl #(
    parameter int Rows         = 16,
    parameter int Cols         = 8,
    parameter int SENSE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            re_n,
    input  logic [Rows-1:0] row_sel,
    input  logic [Cols-1:0] col_sel,
    input  logic            bl_in,
    output logic            precharge,
    output logic [Rows-1:0] wl_row,
    output logic [Cols-1:0] bl_col,
    output logic            sense_en,
    output logic            dout,
    output logic            rd_valid,
    output logic            busy,
    output logic            sel_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRECH = 2'd1,
        SENSE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [Rows-1:0] row_q, row_d;
    logic [Cols-1:0] col_q, col_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            dout_q, dout_d;
    logic            rd_valid_q, rd_valid_d;
    logic            req;

`ifdef ONEHOT_CHECK_EN
    logic            sel_err_q, sel_err_d;
    logic            sel_onehot;
`endif

    // Base accept condition: read requested and both selects name something
    assign req = ~re_n & (|row_sel) & (|col_sel);

`ifdef ONEHOT_CHECK_EN
    assign sel_onehot = $onehot(row_sel) && $onehot(col_sel);
`endif

    // State, captured address, sense counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            dout_q     <= 1'b0;
            rd_valid_q <= 1'b0;
`ifdef ONEHOT_CHECK_EN
            sel_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
`ifdef ONEHOT_CHECK_EN
            sel_err_q  <= sel_err_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE, one precharge cycle, then count down the sense window
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
`ifdef ONEHOT_CHECK_EN
        sel_err_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
`ifdef ONEHOT_CHECK_EN
                    if (sel_onehot) begin
                        row_d   = row_sel;
                        col_d   = col_sel;
                        state_d = PRECH;
                    end else begin
                        sel_err_d = 1'b1;
                    end
`else
                    row_d   = row_sel;
                    col_d   = col_sel;
                    state_d = PRECH;
`endif
                end
            end
            PRECH: begin
                state_d = SENSE;
                cnt_d   = 4'(SENSE_CYCLES - 1);
            end
            SENSE: begin
                if (cnt_q == 4'd0) begin
                    dout_d     = bl_in;
                    rd_valid_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Array controls come only from state and captured registers, never straight from inputs
    assign precharge = (state_q == PRECH);
    assign sense_en  = (state_q == SENSE);
    assign wl_row    = sense_en ? row_q : '0;
    assign bl_col    = sense_en ? col_q : '0;
    assign busy      = (state_q != IDLE);
    assign dout      = dout_q;
    assign rd_valid  = rd_valid_q;
`ifdef ONEHOT_CHECK_EN
    assign sel_err   = sel_err_q;
`else
    assign sel_err   = 1'b0;
`endif

endmodule
